mmu_xlate_ctrl: RTL

Sequencing controller that shares the single TLB search port and address-translation path between the instruction-fetch and data-memory requesters. It sits between the two pipeline memory stages and the TLB array. It does three things:
- arbitrates between the two requesters, round-robin;
- steps each accepted request through segment decode, TLB lookup and exception classification;
- registers a one-cycle result pulse back to the requester that issued it.

It also blocks new lookups while CP0 performs a TLB write.

---
 rtl/mmu_xlate_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mmu_xlate_ctrl.sv
`default_nettype none
// ============================================================================
//  mmu_xlate_ctrl
//  Shares one TLB search port between the inst and data requesters:
//  round-robin grant, segment decode, TLB lookup and exception classification.
//  Revision: 1.0
// ============================================================================
module mmu_xlate_ctrl #(
  parameter int TLB = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_vaddr,
  output logic        inst_accept,
  output logic        inst_valid,
  output logic [31:0] inst_paddr,
  output logic        inst_cached,
  output logic        inst_refill,
  output logic        inst_invalid,
  input  logic        data_req,
  input  logic [31:0] data_vaddr,
  input  logic        data_wr,
  output logic        data_accept,
  output logic        data_valid,
  output logic [31:0] data_paddr,
  output logic        data_cached,
  output logic        data_refill,
  output logic        data_invalid,
  output logic        data_modified,
  output logic [18:0] tlb_vpn2,
  output logic        tlb_odd_page,
  input  logic        tlb_found,
  input  logic [19:0] tlb_pfn,
  input  logic [2:0]  tlb_c,
  input  logic        tlb_d,
  input  logic        tlb_v,
  input  logic [2:0]  cp0_config_k0,
  input  logic        tlbw_req,
  output logic        tlbw_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        side_q;       // 1: current request belongs to the data side
  logic        last_data_q;  // 1: data side won the last grant
  logic        wr_q;
  logic [11:0] offset_q;
  logic        valid_q;
  logic [31:0] paddr_q;
  logic        cached_q;
  logic        refill_q;
  logic        invalid_q;
  logic        modified_q;
  logic [18:0] vpn2_q;
  logic        odd_q;

  logic        arb_en;
  logic        grant_data;
  logic        grant_inst;
  logic [31:0] gnt_vaddr;
  logic        kseg0;
  logic        kseg1;
  logic        lk_refill;
  logic        lk_invalid;
  logic        lk_modified;

  always_comb begin
    arb_en      = (state_q == S_IDLE) && !tlbw_req;
    grant_data  = arb_en && data_req && (!inst_req || !last_data_q);
    grant_inst  = arb_en && inst_req && !grant_data;
    gnt_vaddr   = grant_data ? data_vaddr : inst_vaddr;
    kseg0       = (gnt_vaddr[31:29] == 3'b100);
    kseg1       = (gnt_vaddr[31:29] == 3'b101);
    lk_refill   = !tlb_found;
    lk_invalid  = tlb_found && !tlb_v;
    lk_modified = tlb_found && tlb_v && !tlb_d && wr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      side_q      <= 1'b0;
      last_data_q <= 1'b0;
      wr_q        <= 1'b0;
      offset_q    <= 12'd0;
      valid_q     <= 1'b0;
      paddr_q     <= 32'd0;
      cached_q    <= 1'b0;
      refill_q    <= 1'b0;
      invalid_q   <= 1'b0;
      modified_q  <= 1'b0;
      vpn2_q      <= 19'd0;
      odd_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_data || grant_inst) begin
            side_q      <= grant_data;
            last_data_q <= grant_data;
            wr_q        <= grant_data && data_wr;
            offset_q    <= gnt_vaddr[11:0];
            if (!kseg0 && !kseg1 && (TLB != 0)) begin
              vpn2_q  <= gnt_vaddr[31:13];
              odd_q   <= gnt_vaddr[12];
              state_q <= S_LOOKUP;
            end else begin
              valid_q  <= 1'b1;
              cached_q <= kseg0 && (cp0_config_k0 == 3'd3);
              if (kseg0)
                paddr_q <= gnt_vaddr - 32'h8000_0000;
              else if (kseg1)
                paddr_q <= gnt_vaddr - 32'hA000_0000;
              else
                paddr_q <= gnt_vaddr;
              state_q <= S_RESP;
            end
          end
        end
        S_LOOKUP: begin
          valid_q    <= 1'b1;
          refill_q   <= lk_refill;
          invalid_q  <= lk_invalid;
          modified_q <= lk_modified;
          // Any exception suppresses the translated address
          if (lk_refill || lk_invalid || lk_modified) begin
            paddr_q  <= 32'd0;
            cached_q <= 1'b0;
          end else begin
            paddr_q  <= {tlb_pfn, offset_q};
            cached_q <= (tlb_c == 3'd3);
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          valid_q    <= 1'b0;
          paddr_q    <= 32'd0;
          cached_q   <= 1'b0;
          refill_q   <= 1'b0;
          invalid_q  <= 1'b0;
          modified_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Grants are masked while reset is held so no accept leaks out of reset
  assign inst_accept   = resetn && grant_inst;
  assign data_accept   = resetn && grant_data;
  assign tlbw_ack      = resetn && (state_q == S_IDLE) && tlbw_req;

  assign inst_valid    = valid_q && !side_q;
  assign inst_paddr    = side_q ? 32'd0 : paddr_q;
  assign inst_cached   = !side_q && cached_q;
  assign inst_refill   = !side_q && refill_q;
  assign inst_invalid  = !side_q && invalid_q;

  assign data_valid    = valid_q && side_q;
  assign data_paddr    = side_q ? paddr_q : 32'd0;
  assign data_cached   = side_q && cached_q;
  assign data_refill   = side_q && refill_q;
  assign data_invalid  = side_q && invalid_q;
  assign data_modified = side_q && modified_q;

  assign tlb_vpn2      = vpn2_q;
  assign tlb_odd_page  = odd_q;

endmodule
`default_nettype wire
